// File: rtl/valid_ready_skid_pkg.sv
// Shared definitions for the valid/ready register slice.
package valid_ready_skid_pkg;
    localparam int unsigned DEFAULT_DATA_W = 8;
endpackage

// File: rtl/valid_ready_skid.sv
// Single-stage valid/ready register slice with a one-entry skid buffer.
// All outputs are flops, so both the forward and backward paths are cut.
module valid_ready_skid
    import valid_ready_skid_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
);

    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic              in_fire;
    logic              drain;
    logic              skid_v_nxt;

    assign in_fire    = valid_i & ready_o;
    assign drain      = ~valid_o | ready_i;
    // The skid entry only fills while the main register is stalled.
    assign skid_v_nxt = drain ? 1'b0 : (skid_v | in_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            skid_v  <= 1'b0;
            skid_d  <= '0;
            ready_o <= 1'b0;
        end else begin
            skid_v  <= skid_v_nxt;
            ready_o <= ~skid_v_nxt;
            if (drain) begin
                if (skid_v) begin
                    data_o  <= skid_d;
                    valid_o <= 1'b1;
                end else if (in_fire) begin
                    data_o  <= data_i;
                    valid_o <= 1'b1;
                end else begin
                    valid_o <= 1'b0;
                end
            end else if (in_fire) begin
                skid_d <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_valid_ready_skid.sv
// Self-checking bench for valid_ready_skid against a queue-based FIFO model.
module tb_valid_ready_skid;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       last_rst = 1'b1;

    logic       obs_valid, obs_ready;
    logic [7:0] obs_data;
    logic       exp_valid, exp_ready;
    logic [7:0] exp_data;
    logic       in_fire, out_fire;

    valid_ready_skid #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, sample before the edge, then advance the model past it.
    task automatic step(input logic r, input logic vi, input logic [7:0] di, input logic ri);
        rst = r; valid_i = vi; data_i = di; ready_i = ri;
        @(negedge clk);
        obs_valid = valid_o; obs_ready = ready_o; obs_data = data_o;
        exp_valid = (q.size() > 0);
        exp_ready = !last_rst && (q.size() < 2);
        exp_data  = (q.size() > 0) ? q[0] : 8'h00;
        in_fire   = vi && obs_ready;
        out_fire  = obs_valid && ri;
        @(posedge clk);
        if (r) begin
            q.delete();
            last_rst = 1'b1;
        end else begin
            last_rst = 1'b0;
            if (out_fire && q.size() > 0) void'(q.pop_front());
            if (in_fire) q.push_back(di);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h08, 1'b0);
            if (i > 0) begin
                checks++;
                if (obs_valid !== 1'b0 || obs_data !== 8'h00 || obs_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold: valid=%b data=%h ready=%b, want 0 00 0", obs_valid, obs_data, obs_ready);
                end
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (obs_valid !== 1'b0 || obs_data !== 8'h00 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: valid=%b data=%h ready=%b, want 0 00 0", obs_valid, obs_data, obs_ready);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", obs_ready, obs_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want_d[4] = '{8'h00, 8'h3C, 8'h48, 8'h00};
        logic       want_v[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       vi_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] di_seq[4] = '{8'h3C, 8'h48, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, vi_seq[i], di_seq[i], 1'b1);
            checks++;
            if (obs_valid !== want_v[i] || obs_ready !== 1'b1 || (want_v[i] && obs_data !== want_d[i])) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b data=%h ready=%b, want %b %h 1",
                         i, obs_valid, obs_data, obs_ready, want_v[i], want_d[i]);
            end
        end
    endtask

    task automatic test_stall_skid();
        logic       vi_seq[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] di_seq[6] = '{8'h3C, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       ri_seq[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       want_v[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] want_d[6] = '{8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h24, 8'h00};
        logic       want_r[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, vi_seq[i], di_seq[i], ri_seq[i]);
            checks++;
            if (obs_valid !== want_v[i] || obs_ready !== want_r[i] || (want_v[i] && obs_data !== want_d[i])) begin
                errors++;
                $display("FAIL stall_skid[%0d]: valid=%b data=%h ready=%b, want %b %h %b",
                         i, obs_valid, obs_data, obs_ready, want_v[i], want_d[i], want_r[i]);
            end
        end
    endtask

    task automatic test_held_source();
        int n_in = 0;
        int n_out = 0;
        logic vi_seq[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ri_seq[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, vi_seq[i], 8'h24, ri_seq[i]);
            if (in_fire) n_in++;
            if (out_fire) begin
                n_out++;
                checks++;
                if (obs_data !== 8'h24) begin
                    errors++;
                    $display("FAIL held_data[%0d]: got %h want 24", i, obs_data);
                end
            end
        end
        checks++;
        if (n_in != 2 || n_out != 2) begin
            errors++;
            $display("FAIL held_counts: in=%0d out=%0d, want 2 2", n_in, n_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] next_d = 8'h00;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        int         n_in = 0;
        int         n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            logic vi, ri;
            vi = 1'($urandom_range(0, 1));
            ri = 1'($urandom_range(0, 1));
            step(1'b0, vi, next_d, ri);
            checks++;
            if (obs_valid !== exp_valid || obs_ready !== exp_ready || (exp_valid && obs_data !== exp_data)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b data=%h ready=%b, want %b %h %b",
                         i, obs_valid, obs_data, obs_ready, exp_valid, exp_data, exp_ready);
            end
            if (prev_stall) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable[%0d]: valid=%b data=%h, want 1 %h", i, obs_valid, obs_data, prev_data);
                end
            end
            prev_stall = obs_valid && !ri;
            prev_data  = obs_data;
            if (in_fire) begin
                next_d = next_d + 8'd1;
                n_in++;
            end
            if (out_fire) n_out++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (out_fire) n_out++;
        end
        checks++;
        if (n_out != n_in || q.size() != 0) begin
            errors++;
            $display("FAIL random_count: out=%0d in=%0d left=%0d", n_out, n_in, q.size());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h11 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: valid=%b data=%h ready=%b, want 1 11 0", obs_valid, obs_data, obs_ready);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_reset: valid=%b ready=%b, want 0 0", obs_valid, obs_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_after[%0d]: valid=%b data=%h ready=%b, want 0 -- 1", i, obs_valid, obs_data, obs_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; ready_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall_skid();
        test_held_source();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
